// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit counter states and reset value for the branch predictor
package bp_pkg;
  typedef logic [1:0] bp_ctr_t;
  localparam bp_ctr_t BP_SNT = 2'b00;
  localparam bp_ctr_t BP_WNT = 2'b01;
  localparam bp_ctr_t BP_WT = 2'b10;
  localparam bp_ctr_t BP_ST = 2'b11;
  localparam bp_ctr_t BP_CTR_INIT = BP_WNT;
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: combinational 2-bit saturating counter next state
// Ports: i_ctr current state, i_taken resolved outcome, o_ctr next state.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_ctr_t i_ctr,
  input  logic    i_taken,
  output bp_ctr_t o_ctr
);
  always_comb o_ctr = i_taken ? ((i_ctr == BP_ST) ? BP_ST : i_ctr + 2'd1)
                              : ((i_ctr == BP_SNT) ? BP_SNT : i_ctr - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal 2-bit counter table plus direct-mapped BTB
// Ports: clk/rst (async, active-high); fetch_pc -> prediction, pred_target
// (combinational lookup); upd_* resolved branch feedback from execute;
// perf_branches/perf_mispredicts present only when BP_PERF_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            prediction,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict
`ifdef BP_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);
  localparam int N = 1 << INDEX_BITS;
  localparam int TW = XLEN - INDEX_BITS - 2;
  bp_ctr_t r_ctr [N];
  logic [N-1:0] r_valid;
  logic [TW-1:0] r_tag [N];
  logic [XLEN-1:0] r_target [N];
  logic [INDEX_BITS-1:0] w_fidx, w_uidx;
  logic w_fhit, w_uhit, w_unused;
  bp_ctr_t w_ctr_inc, w_ctr_new;
  assign w_fidx = fetch_pc[INDEX_BITS+1:2];
  assign w_uidx = upd_pc[INDEX_BITS+1:2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == fetch_pc[XLEN-1:INDEX_BITS+2]);
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == upd_pc[XLEN-1:INDEX_BITS+2]);
  assign prediction = r_ctr[w_fidx][1] && w_fhit;
  assign pred_target = prediction ? r_target[w_fidx] : '0;
  assign w_unused = ^{fetch_pc[1:0], upd_pc[1:0], upd_mispredict};
  bp_sat_counter u_ctr (
    .i_ctr  (r_ctr[w_uidx]),
    .i_taken(upd_taken),
    .o_ctr  (w_ctr_inc)
  );
  // a taken branch claiming an entry owned by another PC restarts at weak-taken
  assign w_ctr_new = (upd_taken && !w_uhit) ? BP_WT : w_ctr_inc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < N; k++) r_ctr[k] <= BP_CTR_INIT;
      r_valid <= '0;
    end else if (upd_valid) begin
      r_ctr[w_uidx] <= w_ctr_new;
      if (upd_taken) r_valid[w_uidx] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (!rst && upd_valid && upd_taken) begin
      r_tag[w_uidx] <= upd_pc[XLEN-1:INDEX_BITS+2];
      r_target[w_uidx] <= upd_target;
    end
`ifdef BP_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_branches <= '0;
      perf_mispredicts <= '0;
    end else if (upd_valid) begin
      perf_branches <= perf_branches + 32'd1;
      if (upd_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plan plus randomized traffic against a table model
module tb_branch_predictor;
  logic clk = 0, rst = 1;
  logic [31:0] fetch_pc = 0, upd_pc = 0, upd_target = 0, pred_target;
  logic upd_valid = 0, upd_taken = 0, upd_mispredict = 0, prediction;
`ifdef BP_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif
  int n_checks = 0, n_errors = 0;
  int m_ctr [64];
  bit m_val [64];
  logic [31:0] m_tag [64], m_tgt [64];
  logic p_o;
  logic [31:0] t_o;
  always #5 clk = ~clk;
  branch_predictor #(.INDEX_BITS(6), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .prediction(prediction),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict)
`ifdef BP_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 0;
    end
  endfunction
  function automatic bit m_hit(input logic [31:0] pc);
    int i = int'((pc >> 2) % 64);
    return m_val[i] && m_tag[i] == (pc >> 8);
  endfunction
  function automatic void m_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    int i = int'((pc >> 2) % 64);
    if (tk) begin
      m_ctr[i] = m_hit(pc) ? ((m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1) : 2;
      m_val[i] = 1;
      m_tag[i] = pc >> 8;
      m_tgt[i] = tg;
    end else m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
  endfunction
  task automatic cycle(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic um,
                       output logic p, output logic [31:0] t);
    logic mp;
    logic [31:0] mt;
    int i;
    fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_mispredict = um;
    @(negedge clk);
    i = int'((fpc >> 2) % 64);
    mp = m_hit(fpc) && m_ctr[i] >= 2;
    mt = mp ? m_tgt[i] : 32'h0;
    check("model_pred", {31'b0, prediction}, {31'b0, mp});
    check("model_target", pred_target, mt);
    p = prediction;
    t = pred_target;
    @(posedge clk);
    if (uv) m_update(upc, ut, utg);
    #1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    cycle(32'h0, 1'b1, pc, tk, tg, 1'b0, p_o, t_o);
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic ep, input logic [31:0] et);
    cycle(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, p_o, t_o);
    check({tag, "_pred"}, {31'b0, p_o}, {31'b0, ep});
    check({tag, "_target"}, t_o, et);
  endtask
  task automatic async_reset(input string tag, input logic [31:0] pc);
    fetch_pc = pc;
    upd_valid = 1; upd_pc = pc; upd_taken = 1; upd_target = 32'h1234;
    #3 rst = 1;
    #1;
    check({tag, "_pred"}, {31'b0, prediction}, 32'h0);
    check({tag, "_target"}, pred_target, 32'h0);
`ifdef BP_PERF_EN
    check({tag, "_perf_br"}, perf_branches, 32'h0);
    check({tag, "_perf_mis"}, perf_mispredicts, 32'h0);
`endif
    @(posedge clk);
    #1;
    upd_valid = 0;
    @(negedge clk);
    rst = 0;
    m_reset();
    @(posedge clk);
    #1;
  endtask
  initial begin
    m_reset();
    fetch_pc = 32'h100;
    #7;
    check("reset_pred", {31'b0, prediction}, 32'h0);
    check("reset_target", pred_target, 32'h0);
    #5 rst = 0;
    @(posedge clk);
    #1;
    look("post_reset", 32'h100, 0, 0);
    upd(32'h100, 1, 32'h140);
    upd(32'h100, 1, 32'h140);
    look("trained", 32'h100, 1, 32'h140);
    cycle(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, p_o, t_o);
    check("same_cycle_old", {31'b0, p_o}, 32'h1);
    look("after_one_nt", 32'h100, 1, 32'h140);
    upd(32'h100, 0, 0);
    look("after_two_nt", 32'h100, 0, 0);
    upd(32'h100, 1, 32'h140);
    look("alias_trained", 32'h100, 1, 32'h140);
    look("alias_other", 32'h200, 0, 0);
    upd(32'h200, 1, 32'h300);
    look("alias_evicted", 32'h100, 0, 0);
    look("alias_new", 32'h200, 1, 32'h300);
    for (int k = 0; k < 5; k++) upd(32'h10C, 1, 32'h500);
    upd(32'h10C, 0, 0);
    look("sat_hi_1", 32'h10C, 1, 32'h500);
    upd(32'h10C, 0, 0);
    look("sat_hi_2", 32'h10C, 0, 0);
    for (int k = 0; k < 3; k++) upd(32'h10C, 0, 0);
    upd(32'h10C, 1, 32'h500);
    look("sat_lo_1", 32'h10C, 0, 0);
    upd(32'h10C, 1, 32'h500);
    look("sat_lo_2", 32'h10C, 1, 32'h500);
    async_reset("async_rst", 32'h10C);
    look("after_rst", 32'h10C, 0, 0);
`ifdef BP_PERF_EN
    for (int k = 0; k < 10; k++)
      cycle(32'h0, 1'b1, 32'h80 + 32'(k * 4), k[0], 32'h900, (k % 3) == 0, p_o, t_o);
    #1;
    check("perf_branches", perf_branches, 32'd10);
    check("perf_mispredicts", perf_mispredicts, 32'd4);
    cycle(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, p_o, t_o);
    check("perf_idle_br", perf_branches, 32'd10);
    check("perf_idle_mis", perf_mispredicts, 32'd4);
    async_reset("perf_rst", 32'h84);
`endif
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] fpc, upc;
      fpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) upc = fpc;
      cycle(fpc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), p_o, t_o);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
